// File: rtl/stream_arb_pkg.sv
// Shared constants and width helper for the stream round-robin arbiter.
package stream_arb_pkg;

    localparam int DW_DEF        = 32;
    localparam int N_DEF         = 4;
    localparam int MAX_BURST_DEF = 4;

    // Index width that never collapses to zero bits, so N=1 still gets a 1-bit field.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// N-requester upstream valid/ready bundle plus the single downstream stream.
interface stream_rr_arbiter_if import stream_arb_pkg::*; #(
    parameter int DW = DW_DEF,
    parameter int N  = N_DEF
) ();

    localparam int IDX_W = clog2_min1(N);

    logic [N-1:0]    up_valid;
    logic [N*DW-1:0] up_data;
    logic [N-1:0]    up_ready;
    logic            down_valid;
    logic [DW-1:0]   down_data;
    logic [IDX_W-1:0] down_src;
    logic            down_ready;

    modport master (
        output up_valid, up_data, down_ready,
        input  up_ready, down_valid, down_data, down_src
    );

    modport slave (
        input  up_valid, up_data, down_ready,
        output up_ready, down_valid, down_data, down_src
    );

endinterface

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the start index.
module rr_pick import stream_arb_pkg::*; #(
    parameter  int N     = N_DEF,
    localparam int IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] sel,
    output logic             sel_vld
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDX_W:0] offs;
    logic [IDX_W:0] sum;

    always_comb begin
        dbl     = {req, req} >> start;
        rot     = dbl[N-1:0];
        sel_vld = |req;
        offs    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offs = (IDX_W + 1)'(i);
            end
        end
        // Undo the rotation: both terms are below N, so one conditional subtract wraps.
        sum = {1'b0, start} + offs;
        if (sum >= (IDX_W + 1)'(N)) begin
            sum = sum - (IDX_W + 1)'(N);
        end
        sel = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// N:1 valid/ready arbiter, round-robin with bounded burst lock, one registered output stage.
// Optional per-requester beat counters (stat_beats) when STREAM_RR_ARBITER_STATS_EN is defined.
module stream_rr_arbiter import stream_arb_pkg::*; #(
    parameter int DW        = DW_DEF,
    parameter int N         = N_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
`ifdef STREAM_RR_ARBITER_STATS_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic                clk,
    input  logic                rst,
    stream_rr_arbiter_if.slave  bus
`ifdef STREAM_RR_ARBITER_STATS_EN
    ,
    output logic [N*CNT_W-1:0]  stat_beats
`endif
);

    localparam int IDX_W = clog2_min1(N);
    localparam int BW    = clog2_min1(MAX_BURST + 1);

    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] rr_sel;
    logic [IDX_W-1:0] sel;
    logic [BW-1:0]    burst_cnt;
    logic             rr_vld;
    logic             sel_vld;
    logic             lock;
    logic             load;

    assign load  = !bus.down_valid || bus.down_ready;
    assign start = (last == IDX_W'(N - 1)) ? '0 : last + 1'b1;

    rr_pick #(.N(N)) u_pick (
        .req     (bus.up_valid),
        .start   (start),
        .sel     (rr_sel),
        .sel_vld (rr_vld)
    );

    // burst_cnt==0 only right after reset: no owner yet, so the first grant rotates from index 0.
    assign lock    = bus.up_valid[last] && (burst_cnt != '0) && (burst_cnt < BW'(MAX_BURST));
    assign sel     = lock ? last : rr_sel;
    assign sel_vld = lock || rr_vld;

    always_comb begin
        bus.up_ready = '0;
        if (rst && load && sel_vld) begin
            bus.up_ready[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.down_valid <= 1'b0;
            bus.down_data  <= '0;
            bus.down_src   <= '0;
            last           <= IDX_W'(N - 1);
            burst_cnt      <= '0;
        end else if (load) begin
            if (sel_vld) begin
                bus.down_valid <= 1'b1;
                bus.down_data  <= bus.up_data[sel*DW +: DW];
                bus.down_src   <= sel;
                last           <= sel;
                burst_cnt      <= (sel == last && burst_cnt < BW'(MAX_BURST)) ?
                                  burst_cnt + BW'(1) : BW'(1);
            end else begin
                bus.down_valid <= 1'b0;
            end
        end
    end

`ifdef STREAM_RR_ARBITER_STATS_EN
    for (genvar gi = 0; gi < N; gi++) begin : g_stat
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt <= '0;
            end else if (bus.up_valid[gi] && bus.up_ready[gi] && cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign stat_beats[gi*CNT_W +: CNT_W] = cnt;
    end
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: directed vector table, hand sequences and random traffic vs a reference model.
module tb_stream_rr_arbiter;
    import stream_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 4;
`ifdef STREAM_RR_ARBITER_STATS_EN
    localparam int CNT_W = 4;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    stream_rr_arbiter_if #(.DW(DW), .N(N)) bus ();

`ifdef STREAM_RR_ARBITER_STATS_EN
    logic [N*CNT_W-1:0] stat_beats;
`endif

    stream_rr_arbiter #(
        .DW(DW), .N(N), .MAX_BURST(MB)
`ifdef STREAM_RR_ARBITER_STATS_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef STREAM_RR_ARBITER_STATS_EN
        , .stat_beats (stat_beats)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: current owner, length of its current run, and the output register.
    int          m_owner;
    int          m_run;
    int          m_src;
    bit          m_valid;
    logic [DW-1:0] m_data;
    int          seq   [N];
    int          m_cnt [N];
    logic [N-1:0] last_acc;

    typedef struct {
        bit           rst_first;
        logic [N-1:0] uv;
        logic         dr;
        int           src;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] beat(input int i);
        return {8'(i), 24'(seq[i])};
    endfunction

    function automatic int m_pick(input logic [N-1:0] uv);
        if (m_run > 0 && m_run < MB && uv[m_owner]) return m_owner;
        for (int k = 1; k <= N; k++) begin
            if (uv[(m_owner + k) % N]) return (m_owner + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = N - 1;
        m_run   = 0;
        m_src   = 0;
        m_valid = 1'b0;
        m_data  = '0;
    endtask

    task automatic step(input logic [N-1:0] uv, input logic dr);
        int            p;
        bit            ld;
        logic [N-1:0]  er;
        logic [DW-1:0] ed;
        bus.up_valid   = uv;
        bus.down_ready = dr;
        for (int i = 0; i < N; i++) bus.up_data[i*DW +: DW] = beat(i);
        @(negedge clk);
        ld = !m_valid || dr;
        p  = m_pick(uv);
        er = '0;
        ed = '0;
        if (ld && p >= 0) begin
            er[p] = 1'b1;
            ed    = beat(p);
            m_cnt[p]++;
        end
        chk("up_ready", 64'(bus.up_ready), 64'(er));
        last_acc = uv & bus.up_ready;
        for (int i = 0; i < N; i++) if (last_acc[i]) seq[i]++;
        @(posedge clk);
        if (ld) begin
            if (p >= 0) begin
                m_run   = (p == m_owner && m_run < MB) ? m_run + 1 : 1;
                m_owner = p;
                m_valid = 1'b1;
                m_data  = ed;
                m_src   = p;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk("down_valid", 64'(bus.down_valid), 64'(m_valid));
        chk("down_data", 64'(bus.down_data), 64'(m_data));
        chk("down_src", 64'(bus.down_src), 64'(m_src));
    endtask

    // Called just after a rising edge; asserts reset mid-cycle and checks the immediate effect.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_down_valid", 64'(bus.down_valid), 64'd0);
        chk("rst_up_ready", 64'(bus.up_ready), 64'd0);
        chk("rst_down_data", 64'(bus.down_data), 64'd0);
        chk("rst_down_src", 64'(bus.down_src), 64'd0);
        repeat (2) @(negedge clk);
        rst          = 1'b1;
        bus.up_valid = '0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] pend;
        logic         dr;

        bus.up_valid   = '0;
        bus.up_data    = '0;
        bus.down_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            seq[i]   = 0;
            m_cnt[i] = 0;
        end
        model_reset();

        for (int k = 0; k <= 16; k++) tbl.push_back('{k == 0, 4'b1111, 1'b1, (k / 4) % 4});
        for (int k = 0; k < 10; k++)  tbl.push_back('{k == 0, 4'b0100, 1'b1, 2});
        tbl.push_back('{1'b1, 4'b0010, 1'b1, 1});
        tbl.push_back('{1'b0, 4'b1011, 1'b1, 1});
        tbl.push_back('{1'b0, 4'b1001, 1'b1, 3});
        tbl.push_back('{1'b0, 4'b0001, 1'b1, 0});
        tbl.push_back('{1'b1, 4'b1010, 1'b1, 1});

        bus.up_valid = 4'b1111;
        #1;
        do_reset();

        foreach (tbl[t]) begin
            if (tbl[t].rst_first) do_reset();
            step(tbl[t].uv, tbl[t].dr);
            chk("tbl_src", 64'(bus.down_src), 64'(tbl[t].src));
            chk("tbl_valid", 64'(bus.down_valid), 64'd1);
        end

        // Backpressure: output holds for three stalled cycles, then drains with a new grant.
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
        repeat (3) begin
            step(4'b1111, 1'b0);
            chk("bp_up_ready", 64'(bus.up_ready), 64'd0);
        end
        step(4'b1111, 1'b1);
        chk("bp_resume_acc", 64'(last_acc != '0), 64'd1);

        do_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;

        pend = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) if (!pend[i]) pend[i] = 1'($urandom_range(0, 1));
            dr = ($urandom_range(0, 3) != 0);
            step(pend, dr);
            pend = pend & ~last_acc;
        end

`ifdef STREAM_RR_ARBITER_STATS_EN
        for (int i = 0; i < N; i++) begin
            chk("stat_beats", 64'(stat_beats[i*CNT_W +: CNT_W]),
                64'((m_cnt[i] > (2**CNT_W - 1)) ? (2**CNT_W - 1) : m_cnt[i]));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Shares one valid/ready downstream stream (e.g. into custom_logic) between N upstream valid/ready sources (e.g. multiple generators).
- Uses round-robin arbitration with bounded burst lock.
- Has one registered output stage, so latency is 1 cycle and throughput is 1 beat/cycle.
- Does not modify payload; tags each output beat with its source index.

Parameters:
- DW, 32, data width per beat
- N, 4, number of requesters (>=1)
- MAX_BURST, 4, max consecutive beats granted to one owner while others wait (>=1)
- CNT_W, 16, width of per-requester stats counters (optional feature only)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous assert, active-low (rst=0 resets); release synchronised externally
- up_valid  in  N  per-requester valid
- up_data  in  N*DW  per-requester data; requester i occupies bits [i*DW +: DW]
- up_ready  out  N  per-requester ready
- down_valid  out  1  output beat valid (registered)
- down_data  out  DW  output beat data (registered)
- down_src  out  IDX_W  source index of current output beat; IDX_W = max(1, clog2(N))
- down_ready  in  1  downstream ready

Behaviour:
- Reset (rst=0, immediate):
  - down_valid=0, down_data=0, down_src=0.
  - last=N-1, burst_cnt=0.
  - up_ready=0 while in reset.
- Load condition: load = !down_valid || down_ready.
- Selection (combinational, from up_valid, last, burst_cnt):
  - Lock: pick owner=last if up_valid[last] && burst_cnt<MAX_BURST.
  - Otherwise rotate: first i with up_valid[i], scanning (last+1)..(last+N) mod N.
  - If the only valid requester is last and burst_cnt==MAX_BURST, last is still picked; a new burst starts.
- Handshake:
  - up_ready[i] = load && sel_vld && sel==i.
  - At most one up_ready is high per cycle.
  - up_ready may depend combinationally on up_valid.
- On a clock edge with load:
  - If sel_vld: down_valid<=1, down_data<=up_data[sel], down_src<=sel, last<=sel.
  - burst_cnt <= (sel==last && burst_cnt<MAX_BURST) ? burst_cnt+1 : 1.
  - If !sel_vld: down_valid<=0; data, src and burst state are held.
- No load (down_valid && !down_ready): all output registers hold; arbitration state holds; no up_ready.
- Lock release: when the owner drops up_valid, the lock releases that same cycle and the rotation proceeds from the owner.
- MAX_BURST=1: pure round-robin.
- N=1: acts as a plain 1-deep pipeline register; down_src=0.
- Protocol: upstream holds data while valid && !ready; the arbiter does not check this.
- Reset mid-operation: any in-flight output beat is discarded. The first grant after release goes to the lowest valid index.

Optional Feature:
- Macro STREAM_RR_ARBITER_STATS_EN.
- Defined:
  - Adds output port stat_beats [N*CNT_W].
  - Per-requester counter increments on each accepted up beat (up_valid && up_ready).
  - Counters saturate at all-ones and reset to 0.
- Undefined: no port, no counters, no extra logic.

Decomposition:
- Package stream_arb_pkg holds:
  - function clog2_min1(n)
  - default constants DW_DEF=32, N_DEF=4, MAX_BURST_DEF=4
  - nothing else
- Sub-module rr_pick (purely combinational):
  - Inputs: req[N], start index.
  - Outputs: sel, sel_vld.
  - Implementation: double-width rotate plus priority encode.
  - Instantiated once; lock override is applied in the parent.

Test Plan:
- Reset: traffic running, drive rst=0 mid-beat -> down_valid=0 in the same cycle, up_ready=0. After release, with up_valid=4'b1010, first down_src=1.
- Fairness/burst: N=4, MAX_BURST=4, all up_valid=1, down_ready=1 -> down_src = 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0…, no bubbles, data matches per-source counters.
- Single source: only up_valid[2]=1 for 10 beats -> 10 consecutive beats with down_src=2, no gaps despite MAX_BURST=4.
- Backpressure: down_valid=1, down_ready=0 for 3 cycles -> down_data/down_src stable, up_ready=0000. When down_ready rises, the next beat is accepted in that cycle.
- Lock release: requester 1 sends 2 beats then drops valid, requesters 0 and 3 waiting -> next down_src=3, then 0.
- Stats (macro defined): fairness scenario for 32 beats -> stat_beats = 8,8,8,8. With CNT_W=4 and 20 beats from source 0 -> stat_beats[0]=15.
